hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline; replaces the ad-hoc load-use stall logic inside the decode stage.
- Combines three sources:
  - load-use hazards;
  - branch-in-ID operand hazards;
  - a multi-cycle mul/div unit in EX that freezes the front of the pipe until it completes.
- Drives the PC/IF-ID write enables and the pipeline-register flush controls.
- Keeps a saturating stall-cycle counter and a mul/div timeout error flag.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 34 +++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the stall/flush sequencer.
// Contents: mul/div FSM state encoding, register-zero constant, and the
// default mul/div wait limit.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MDWAIT = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MD_TIMEOUT_DEF = 64;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_detect.sv
// Combinational operand-hazard detection between the ID and EX stages.
// Inputs : rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id, BranchInst_id,
//          MemRead_ex, RegWrite_ex, rdAddr_ex
// Outputs: loaduse (load in EX feeds an ID operand),
//          brhaz   (ID branch/JALR needs a result still in EX)
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1Addr_id,
    input  logic [4:0] rs2Addr_id,
    input  logic       rs1Used_id,
    input  logic       rs2Used_id,
    input  logic       BranchInst_id,
    input  logic       MemRead_ex,
    input  logic       RegWrite_ex,
    input  logic [4:0] rdAddr_ex,
    output logic       loaduse,
    output logic       brhaz
);

    logic rd_nonzero_s;
    logic hit1_s;
    logic hit2_s;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign rd_nonzero_s = (rdAddr_ex != REG_ZERO);
    assign hit1_s       = rs1Used_id & (rdAddr_ex == rs1Addr_id) & rd_nonzero_s;
    assign hit2_s       = rs2Used_id & (rdAddr_ex == rs2Addr_id) & rd_nonzero_s;

    assign loaduse = MemRead_ex & (hit1_s | hit2_s);
    // ALU results in EX cannot be forwarded back into ID-stage comparison.
    assign brhaz   = BranchInst_id & RegWrite_ex & (hit1_s | hit2_s);

endmodule : hazard_detect

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs : ID operand info (rs1/rs2 addr+used, BranchInst_id, Branch, Jump),
//          EX info (MemRead_ex, RegWrite_ex, rdAddr_ex, MulDivStart_ex),
//          MulDivDone completion pulse.
// Outputs: PCWrite/IFWrite/IDEXWrite enables, IFIDFlush/IDEXFlush/EXMEMFlush,
//          MulDivBusy (in MDWAIT), sticky MulDivErr timeout flag, and
//          StallCount (saturating count of cycles with PCWrite low).
// Control outputs are combinational from inputs and state so a hazard is
// acted on in the same cycle it appears.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             BranchInst_id,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic             MulDivStart_ex,
    input  logic             MulDivDone,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IDEXWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MulDivBusy,
    output logic             MulDivErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [7:0] MD_LIMIT = 8'(MD_TIMEOUT);

    md_state_e        state_r;
    md_state_e        next_state_s;
    logic [7:0]       wait_cnt_r;
    logic             md_err_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic loaduse_s;
    logic brhaz_s;
    logic pc_write_s;
    logic if_write_s;
    logic idex_write_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic exmem_flush_s;
    logic busy_s;
    logic wait_inc_s;
    logic wait_clr_s;
    logic set_err_s;

    hazard_detect u_detect (
        .rs1Addr_id    (rs1Addr_id),
        .rs2Addr_id    (rs2Addr_id),
        .rs1Used_id    (rs1Used_id),
        .rs2Used_id    (rs2Used_id),
        .BranchInst_id (BranchInst_id),
        .MemRead_ex    (MemRead_ex),
        .RegWrite_ex   (RegWrite_ex),
        .rdAddr_ex     (rdAddr_ex),
        .loaduse       (loaduse_s),
        .brhaz         (brhaz_s)
    );

    // Next-state and stall/flush decode; priority is MDWAIT > mul/div entry > data hazard > branch.
    always_comb begin
        pc_write_s    = 1'b1;
        if_write_s    = 1'b1;
        idex_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        busy_s        = 1'b0;
        next_state_s  = state_r;
        wait_inc_s    = 1'b0;
        wait_clr_s    = 1'b0;
        set_err_s     = 1'b0;
        if (rst) begin
            next_state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (MulDivStart_ex && !MulDivDone) begin
                        // Multi-cycle op: freeze front, bubble behind it.
                        pc_write_s    = 1'b0;
                        if_write_s    = 1'b0;
                        idex_write_s  = 1'b0;
                        exmem_flush_s = 1'b1;
                        next_state_s  = MDWAIT;
                        wait_clr_s    = 1'b1;
                    end else if (loaduse_s || brhaz_s) begin
                        // Operands not ready, so the branch decision is not trusted yet.
                        pc_write_s   = 1'b0;
                        if_write_s   = 1'b0;
                        idex_flush_s = 1'b1;
                    end else if (Branch || Jump) begin
                        ifid_flush_s = 1'b1;
                    end else begin
                        ifid_flush_s = 1'b0;
                    end
                end
                MDWAIT: begin
                    busy_s = 1'b1;
                    if (MulDivDone) begin
                        next_state_s = RUN;
                        wait_clr_s   = 1'b1;
                    end else if (wait_cnt_r == MD_LIMIT) begin
                        // Abort: release the pipe exactly as a Done would.
                        next_state_s = RUN;
                        wait_clr_s   = 1'b1;
                        set_err_s    = 1'b1;
                    end else begin
                        pc_write_s    = 1'b0;
                        if_write_s    = 1'b0;
                        idex_write_s  = 1'b0;
                        exmem_flush_s = 1'b1;
                        wait_inc_s    = 1'b1;
                    end
                end
                default: begin
                    next_state_s = RUN;
                    wait_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // FSM state, mul/div wait counter, sticky error and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= 8'd0;
            md_err_r    <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (wait_clr_s) begin
                wait_cnt_r <= 8'd0;
            end else if (wait_inc_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (set_err_s) begin
                md_err_r <= 1'b1;
            end else begin
                md_err_r <= md_err_r;
            end
            if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign PCWrite    = pc_write_s;
    assign IFWrite    = if_write_s;
    assign IDEXWrite  = idex_write_s;
    assign IFIDFlush  = ifid_flush_s;
    assign IDEXFlush  = idex_flush_s;
    assign EXMEMFlush = exmem_flush_s;
    assign MulDivBusy = busy_s;
    assign MulDivErr  = md_err_r;
    assign StallCount = stall_cnt_r;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (CNT_W=4, MD_TIMEOUT=8).
// Control vector ctl = {PCWrite,IFWrite,IDEXWrite,IFIDFlush,IDEXFlush,
//                       EXMEMFlush,MulDivBusy,MulDivErr}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1Addr_id, rs2Addr_id, rdAddr_ex;
    logic       rs1Used_id, rs2Used_id, BranchInst_id, Branch, Jump;
    logic       MemRead_ex, RegWrite_ex, MulDivStart_ex, MulDivDone;
    logic       PCWrite, IFWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush;
    logic       MulDivBusy, MulDivErr;
    logic [3:0] StallCount;
    logic [7:0] ctl;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(4), .MD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
        .BranchInst_id(BranchInst_id), .Branch(Branch), .Jump(Jump),
        .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .rdAddr_ex(rdAddr_ex),
        .MulDivStart_ex(MulDivStart_ex), .MulDivDone(MulDivDone),
        .PCWrite(PCWrite), .IFWrite(IFWrite), .IDEXWrite(IDEXWrite),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
        .MulDivBusy(MulDivBusy), .MulDivErr(MulDivErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    assign ctl = {PCWrite, IFWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy, MulDivErr};

    localparam logic [7:0] C_IDLE   = 8'hE0;
    localparam logic [7:0] C_STALL  = 8'h28;
    localparam logic [7:0] C_BRANCH = 8'hF0;
    localparam logic [7:0] C_MDENT  = 8'h04;
    localparam logic [7:0] C_MDWAIT = 8'h06;
    localparam logic [7:0] C_MDREL  = 8'hE2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1Addr_id = 5'd0; rs2Addr_id = 5'd0; rdAddr_ex = 5'd0;
        rs1Used_id = 1'b0; rs2Used_id = 1'b0; BranchInst_id = 1'b0;
        Branch = 1'b0; Jump = 1'b0; MemRead_ex = 1'b0; RegWrite_ex = 1'b0;
        MulDivStart_ex = 1'b0; MulDivDone = 1'b0;
    endtask

    task automatic set_loaduse();
        MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd5; rs1Used_id = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Reset overrides a live load-use pattern.
        set_loaduse();
        #2;
        chk("reset_ctl", ctl, C_IDLE);
        chk("reset_cnt", {4'd0, StallCount}, 8'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; clear_inputs();
        #1 chk("idle_ctl", ctl, C_IDLE);

        // Load-use stall on rs1.
        @(negedge clk); set_loaduse();
        #1 chk("loaduse_ctl", ctl, C_STALL);
        @(negedge clk); clear_inputs();
        #1 chk("loaduse_after", ctl, C_IDLE);
        chk("loaduse_cnt", {4'd0, StallCount}, 8'd1);

        // x0 destination never matches.
        @(negedge clk); MemRead_ex = 1'b1; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs1Used_id = 1'b1;
        #1 chk("x0_ctl", ctl, C_IDLE);
        // Matching rs2 field that the instruction does not read.
        @(negedge clk); clear_inputs(); MemRead_ex = 1'b1; rdAddr_ex = 5'd9; rs2Addr_id = 5'd9;
        #1 chk("unused_rs2_ctl", ctl, C_IDLE);
        @(negedge clk); clear_inputs();
        #1 chk("x0_cnt", {4'd0, StallCount}, 8'd1);

        // Branch operand hazard, then the branch flush once EX clears.
        @(negedge clk);
        BranchInst_id = 1'b1; Branch = 1'b1; RegWrite_ex = 1'b1;
        rdAddr_ex = 5'd7; rs2Addr_id = 5'd7; rs2Used_id = 1'b1;
        #1 chk("brhaz_ctl", ctl, C_STALL);
        @(negedge clk); RegWrite_ex = 1'b0; rdAddr_ex = 5'd0;
        #1 chk("branch_flush_ctl", ctl, C_BRANCH);
        @(negedge clk); clear_inputs(); Jump = 1'b1;
        #1 chk("jump_flush_ctl", ctl, C_BRANCH);
        @(negedge clk); clear_inputs();
        #1 chk("branch_cnt", {4'd0, StallCount}, 8'd2);

        // Single-cycle mul/div: no freeze.
        @(negedge clk); MulDivStart_ex = 1'b1; MulDivDone = 1'b1;
        #1 chk("md1_ctl", ctl, C_IDLE);
        @(negedge clk); clear_inputs();
        #1 chk("md1_after", ctl, C_IDLE);
        chk("md1_cnt", {4'd0, StallCount}, 8'd2);

        // Multi-cycle mul/div, Done on the 4th cycle after start.
        @(negedge clk); MulDivStart_ex = 1'b1;
        #1 chk("md_entry", ctl, C_MDENT);
        @(negedge clk); clear_inputs();
        #1 chk("md_wait1", ctl, C_MDWAIT);
        @(negedge clk); set_loaduse(); Branch = 1'b1; Jump = 1'b1;
        #1 chk("md_wait2_ignore", ctl, C_MDWAIT);
        @(negedge clk); clear_inputs();
        #1 chk("md_wait3", ctl, C_MDWAIT);
        @(negedge clk); MulDivDone = 1'b1;
        #1 chk("md_release", ctl, C_MDREL);
        @(negedge clk); clear_inputs();
        #1 chk("md_back_run", ctl, C_IDLE);
        chk("md_cnt", {4'd0, StallCount}, 8'd6);

        // Clean reset before the timeout case.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1 chk("rst2_cnt", {4'd0, StallCount}, 8'd0);

        // Timeout: 8 wait cycles, release, sticky error.
        @(negedge clk); MulDivStart_ex = 1'b1;
        #1 chk("to_entry", ctl, C_MDENT);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); clear_inputs();
            #1 chk($sformatf("to_wait%0d", i), ctl, C_MDWAIT);
        end
        @(negedge clk);
        #1 chk("to_release", ctl, C_MDREL);
        @(negedge clk);
        #1 chk("to_err", ctl, C_IDLE | 8'h01);
        chk("to_cnt", {4'd0, StallCount}, 8'd9);
        @(negedge clk); set_loaduse();
        #1 chk("err_sticky_stall", ctl, C_STALL | 8'h01);
        @(negedge clk); clear_inputs();
        #1 chk("err_sticky", ctl, C_IDLE | 8'h01);
        chk("err_cnt", {4'd0, StallCount}, 8'd10);

        // Asynchronous reset in the middle of MDWAIT.
        @(negedge clk); MulDivStart_ex = 1'b1;
        #1 chk("rmd_entry", ctl, C_MDENT | 8'h01);
        @(negedge clk); clear_inputs();
        #1 chk("rmd_wait", ctl, C_MDWAIT | 8'h01);
        #1 rst = 1'b1;
        #1 chk("rmd_reset_ctl", ctl, C_IDLE);
        chk("rmd_reset_cnt", {4'd0, StallCount}, 8'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rmd_run", ctl, C_IDLE);
        @(negedge clk);
        #1 chk("rmd_run2", ctl, C_IDLE);

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); set_loaduse();
        end
        @(negedge clk); clear_inputs();
        #1 chk("sat_cnt", {4'd0, StallCount}, 8'd15);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_loaduse();
        end
        @(negedge clk); clear_inputs();
        #1 chk("sat_hold", {4'd0, StallCount}, 8'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
